// File: rtl/pipe_wbu.sv
// Write-back stage: registers one retiring uop, drives the RF write port and
// the WB->EX forward path, counts retirements, halts on EBREAK.
// Optional commit trace ports are enabled with PIPE_WBU_DIFFTEST_EN.
package pipe_wbu_pkg;
  typedef logic [31:0] ele_t;
  typedef logic [31:0] pc_t;
  typedef enum logic [2:0] {FU_ALU, FU_LOAD, FU_STORE, FU_BRANCH, FU_EBREAK} fu_op_e;
  typedef struct packed {
    pc_t        pc;
    pc_t        dnpc;
    logic [4:0] rd;
    logic       rf_wen;
    fu_op_e     fu_op;
  } uop_info_t;
  typedef struct packed {
    ele_t      alu_res;
    ele_t      lsu_res;
    uop_info_t uop_info;
  } exToWb_t;
endpackage

module pipe_wbu
  import pipe_wbu_pkg::*;
#(
  parameter int CNT_WIDTH      = 64,
  parameter bit HALT_ON_EBREAK = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  exToWb_t              exToWb_i,
  input  logic                 ex_valid_i,
  output logic                 wb_ready_o,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output ele_t                 rf_wdata_o,
  output logic                 wb_fwd_valid_o,
  output logic [4:0]           wb_fwd_rd_o,
  output ele_t                 wb_fwd_data_o,
  output logic [CNT_WIDTH-1:0] retire_cnt_o,
`ifdef PIPE_WBU_DIFFTEST_EN
  output logic                 commit_valid_o,
  output pc_t                  commit_pc_o,
  output pc_t                  commit_dnpc_o,
  output logic                 commit_rf_we_o,
  output logic [4:0]           commit_rd_o,
  output ele_t                 commit_wdata_o,
`endif
  output logic                 halt_o
);

  typedef enum logic {RUN, HALT} state_e;

  state_e               state_q, state_d;
  logic                 valid_q, valid_d;
  logic                 xfer;
  ele_t                 alu_q, alu_d, lsu_q, lsu_d;
  logic [4:0]           rd_q, rd_d;
  logic                 wen_q, wen_d;
  fu_op_e               op_q, op_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  ele_t                 wdata;
  logic                 we;

  assign wb_ready_o = (state_q == RUN);
  assign xfer       = ex_valid_i && wb_ready_o;
  assign valid_d    = xfer;

  always_comb begin
    alu_d = alu_q;
    lsu_d = lsu_q;
    rd_d  = rd_q;
    wen_d = wen_q;
    op_d  = op_q;
    if (xfer) begin
      alu_d = exToWb_i.alu_res;
      lsu_d = exToWb_i.lsu_res;
      rd_d  = exToWb_i.uop_info.rd;
      wen_d = exToWb_i.uop_info.rf_wen;
      op_d  = exToWb_i.uop_info.fu_op;
    end
  end

  assign cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, valid_q};

  // EBREAK still retires in its own WB cycle; HALT takes effect afterwards.
  always_comb begin
    state_d = state_q;
    halt_o  = (state_q == HALT);
    if (state_q == RUN && valid_q && op_q == FU_EBREAK && HALT_ON_EBREAK)
      state_d = HALT;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      valid_q <= 1'b0;
      alu_q   <= '0;
      lsu_q   <= '0;
      rd_q    <= '0;
      wen_q   <= 1'b0;
      op_q    <= FU_ALU;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      alu_q   <= alu_d;
      lsu_q   <= lsu_d;
      rd_q    <= rd_d;
      wen_q   <= wen_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wdata = (op_q == FU_LOAD) ? lsu_q : alu_q;
  // Gating on rd keeps x0 out of both the RF and the forward path.
  assign we    = valid_q && wen_q && (rd_q != 5'd0);

  assign rf_we_o        = we;
  assign rf_waddr_o     = rd_q;
  assign rf_wdata_o     = wdata;
  assign wb_fwd_valid_o = we;
  assign wb_fwd_rd_o    = rd_q;
  assign wb_fwd_data_o  = wdata;
  assign retire_cnt_o   = cnt_q;

`ifdef PIPE_WBU_DIFFTEST_EN
  pc_t pc_q, dnpc_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q   <= '0;
      dnpc_q <= '0;
    end else if (xfer) begin
      pc_q   <= exToWb_i.uop_info.pc;
      dnpc_q <= exToWb_i.uop_info.dnpc;
    end
  end

  assign commit_valid_o = valid_q;
  assign commit_pc_o    = pc_q;
  assign commit_dnpc_o  = dnpc_q;
  assign commit_rf_we_o = we;
  assign commit_rd_o    = rd_q;
  assign commit_wdata_o = wdata;
`else
  logic unused_pc;
  assign unused_pc = ^{exToWb_i.uop_info.pc, exToWb_i.uop_info.dnpc};
`endif

endmodule

// File: tb/tb_pipe_wbu.sv
// Directed bench for pipe_wbu: result select, x0 gating, back-to-back,
// EBREAK halt and asynchronous reset.
module tb_pipe_wbu;
  import pipe_wbu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  exToWb_t     ex;
  logic        ex_valid;
  logic        wb_ready, rf_we, fwd_valid, halt;
  logic [4:0]  rf_waddr, fwd_rd;
  ele_t        rf_wdata, fwd_data;
  logic [63:0] cnt;

  int checks = 0;
  int errors = 0;

  pipe_wbu #(.CNT_WIDTH(64), .HALT_ON_EBREAK(1'b1)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .exToWb_i       (ex),
    .ex_valid_i     (ex_valid),
    .wb_ready_o     (wb_ready),
    .rf_we_o        (rf_we),
    .rf_waddr_o     (rf_waddr),
    .rf_wdata_o     (rf_wdata),
    .wb_fwd_valid_o (fwd_valid),
    .wb_fwd_rd_o    (fwd_rd),
    .wb_fwd_data_o  (fwd_data),
    .retire_cnt_o   (cnt),
    .halt_o         (halt)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input fu_op_e op, input logic [4:0] rd,
                       input logic wen, input ele_t alu, input ele_t lsu);
    ex_valid             = v;
    ex.alu_res           = alu;
    ex.lsu_res           = lsu;
    ex.uop_info.pc       = 32'h8000_0000;
    ex.uop_info.dnpc     = 32'h8000_0004;
    ex.uop_info.rd       = rd;
    ex.uop_info.rf_wen   = wen;
    ex.uop_info.fu_op    = op;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, FU_ALU, 5'd0, 1'b0, '0, '0);
  endtask

  task automatic chk_write(input string tag, input logic [4:0] rd, input ele_t d);
    chk({tag, "_we"},    rf_we,     1);
    chk({tag, "_waddr"}, rf_waddr,  rd);
    chk({tag, "_wdata"}, rf_wdata,  d);
    chk({tag, "_fv"},    fwd_valid, 1);
    chk({tag, "_frd"},   fwd_rd,    rd);
    chk({tag, "_fdata"}, fwd_data,  d);
  endtask

  initial begin
    idle();
    #2;
    chk("rst_ready", wb_ready, 1);
    chk("rst_we",    rf_we,    0);
    chk("rst_fv",    fwd_valid, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_cnt",   cnt,      0);
    chk("rst_halt",  halt,     0);
    #6 rst_ni = 1'b1;
    tick();

    // ADDI x5 = 0x1234
    drive(1'b1, FU_ALU, 5'd5, 1'b1, 32'h1234, 32'h9999);
    tick();
    idle();
    chk_write("addi", 5'd5, 32'h1234);
    chk("addi_cnt0", cnt, 0);
    tick();
    chk("addi_cnt1", cnt, 1);
    chk("addi_drain_we", rf_we, 0);

    // LOAD picks lsu_res
    drive(1'b1, FU_LOAD, 5'd10, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF);
    tick();
    idle();
    chk_write("load", 5'd10, 32'hDEAD_BEEF);
    tick();
    chk("load_cnt", cnt, 2);

    // x0 write then STORE: neither writes nor forwards
    drive(1'b1, FU_ALU, 5'd0, 1'b1, 32'h55, 32'h0);
    tick();
    chk("x0_we", rf_we, 0);
    chk("x0_fv", fwd_valid, 0);
    drive(1'b1, FU_STORE, 5'd3, 1'b0, 32'h100, 32'h0);
    tick();
    idle();
    chk("st_we", rf_we, 0);
    chk("st_fv", fwd_valid, 0);
    chk("st_cnt_mid", cnt, 3);
    tick();
    chk("st_cnt", cnt, 4);

    // Back-to-back x1..x4
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, FU_ALU, 5'(i), 1'b1, 32'(i * 32'h11), 32'h0);
      chk($sformatf("b2b_rdy%0d", i), wb_ready, 1);
      tick();
      chk_write($sformatf("b2b%0d", i), 5'(i), 32'(i * 32'h11));
    end
    idle();
    tick();
    chk("b2b_cnt", cnt, 8);
    chk("b2b_we_off", rf_we, 0);

    // EBREAK followed by ADDI x7; later uop rejected
    drive(1'b1, FU_EBREAK, 5'd0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("eb_halt0", halt, 0);
    chk("eb_ready", wb_ready, 1);
    chk("eb_we", rf_we, 0);
    drive(1'b1, FU_ALU, 5'd7, 1'b1, 32'h77, 32'h0);
    tick();
    chk("eb_halt1", halt, 1);
    chk("eb_ready_lo", wb_ready, 0);
    chk_write("eb_addi", 5'd7, 32'h77);
    chk("eb_cnt9", cnt, 9);
    drive(1'b1, FU_ALU, 5'd9, 1'b1, 32'h99, 32'h0);
    tick();
    chk("hlt_we", rf_we, 0);
    chk("hlt_fv", fwd_valid, 0);
    chk("hlt_cnt", cnt, 10);
    tick();
    chk("hlt_cnt_stop", cnt, 10);
    chk("hlt_still", halt, 1);

    // Fresh run, then async reset while HALT and valid_q=1
    idle();
    rst_ni = 1'b0;
    #1;
    chk("rst2_cnt", cnt, 0);
    rst_ni = 1'b1;
    drive(1'b1, FU_EBREAK, 5'd0, 1'b0, 32'h0, 32'h0);
    tick();
    drive(1'b1, FU_ALU, 5'd7, 1'b1, 32'h7777, 32'h0);
    tick();
    idle();
    chk("pre_halt", halt, 1);
    chk("pre_we", rf_we, 1);
    #1 rst_ni = 1'b0;
    #1;
    chk("ar_we", rf_we, 0);
    chk("ar_fv", fwd_valid, 0);
    chk("ar_wdata", rf_wdata, 0);
    chk("ar_halt", halt, 0);
    chk("ar_ready", wb_ready, 1);
    chk("ar_cnt", cnt, 0);
    #1 rst_ni = 1'b1;

    // RUN again after reset
    drive(1'b1, FU_ALU, 5'd2, 1'b1, 32'hABCD, 32'h0);
    tick();
    idle();
    chk_write("post", 5'd2, 32'hABCD);
    tick();
    chk("post_cnt", cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_wbu.md
Name: pipe_wbu

Overview:
Write-back stage of the in-order pipeline. It sits directly downstream of the execute stage and consumes exToWb_t through a valid/ready handshake. It registers one retiring uop, selects the ALU or LSU result, and drives the register-file write port and the WB→EX forwarding path. It also counts retired instructions and halts the core on EBREAK.

Parameters:
CNT_WIDTH, 64, width of the retired-instruction counter.
HALT_ON_EBREAK, 1, 1 = EBREAK retire enters HALT; 0 = EBREAK retires as a plain uop.

Ports:
clk_i  input  1  clock.
rst_ni  input  1  asynchronous active-low reset.
exToWb_i  input  exToWb_t  alu_res, lsu_res, uop_info (pc, dnpc, rd, rf_wen, fu_op).
ex_valid_i  input  1  EX holds a completed uop.
wb_ready_o  output  1  WB accepts a uop this cycle.
rf_we_o  output  1  register-file write enable.
rf_waddr_o  output  5  destination register.
rf_wdata_o  output  ele_t  write data.
wb_fwd_valid_o  output  1  forward valid to EX.
wb_fwd_rd_o  output  5  forward register index.
wb_fwd_data_o  output  ele_t  forward data.
retire_cnt_o  output  CNT_WIDTH  retired-uop count.
halt_o  output  1  core halted.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - valid_q=0, payload register=0, retire counter=0, FSM=RUN.
  - All outputs 0, except wb_ready_o=1.
- Handshake:
  - wb_ready_o = (state==RUN).
  - Transfer when ex_valid_i && wb_ready_o.
  - There is no backpressure in RUN: WB is a single register that drains every cycle.
- Stage register:
  - valid_q <= ex_valid_i && wb_ready_o.
  - Payload is loaded only on transfer; otherwise it holds.
  - Latency: a uop accepted at edge N drives rf/fwd outputs during cycle N..N+1 (one cycle after acceptance).
- Result select:
  - wdata = (fu_op==LOAD) ? lsu_res : alu_res.
  - STORE and BRANCH carry rf_wen=0 from ID; WB does not override this.
- Write enable:
  - rf_we_o = valid_q && uop.rf_wen && (uop.rd != 0).
  - rf_waddr_o = uop.rd; rf_wdata_o = wdata.
  - x0 is never written.
- Forwarding:
  - wb_fwd_valid_o = rf_we_o; wb_fwd_rd_o = rf_waddr_o; wb_fwd_data_o = rf_wdata_o.
  - These are identical-cycle copies. A write to x0 must never assert forward valid, so EX never forwards to x0.
- Retire counter:
  - Increments by 1 on every cycle valid_q=1, including non-writing uops and EBREAK.
  - Wraps modulo 2^CNT_WIDTH; no saturation.
- FSM (states RUN, HALT):
  - RUN→HALT when valid_q && fu_op==EBREAK && HALT_ON_EBREAK.
  - HALT is terminal; only reset leaves it.
  - In HALT: halt_o=1, wb_ready_o=0, and valid_q clears on the next edge.
  - The EBREAK uop itself retires: counter +1, and its write occurs if rf_wen=1.
  - A uop offered by EX in the same cycle EBREAK sits in WB is accepted, because wb_ready_o is still 1. It retires normally on the next cycle; after that no more uops are accepted.
- Flush: WB does not take flush. The uop in WB is older than any flushing branch and always retires.
- Reset mid-operation: the uop in flight is discarded with no write, the counter clears, and HALT clears.

Optional Feature:
PIPE_WBU_DIFFTEST_EN
- Defined: add outputs commit_valid_o(1) = valid_q, commit_pc_o(pc_t) = uop.pc, commit_dnpc_o(pc_t) = uop.dnpc, commit_rf_we_o/commit_rd_o/commit_wdata_o mirroring the rf port. All are registered with the stage and reset to 0.
- Not defined: these ports and their logic are absent; all other behaviour is unchanged.

Test Plan:
- ADDI result: ex_valid_i=1, rd=5, rf_wen=1, fu_op=ALU, alu_res=0x1234 → next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0x1234, wb_fwd_* match, retire_cnt_o 0→1.
- Load select: fu_op=LOAD, lsu_res=0xDEADBEEF, alu_res=0x80000010, rd=10 → rf_wdata_o=0xDEADBEEF.
- x0 and store: rd=0 with rf_wen=1, then STORE with rf_wen=0 → rf_we_o=0 and wb_fwd_valid_o=0 both cycles; retire_cnt_o increases by 2.
- Back-to-back: 4 consecutive valid uops rd=1..4 → four consecutive write cycles in order, wb_ready_o=1 throughout, retire_cnt_o=4.
- EBREAK: EBREAK followed by ADDI rd=7 → halt_o=1 one cycle after EBREAK is in WB; ADDI writes x7; a subsequent offered uop sees wb_ready_o=0 and no write; retire_cnt_o stops at 2.
- Async reset: drop rst_ni mid-cycle while valid_q=1 and HALT → outputs zero immediately, wb_ready_o=1, state RUN, counter 0.
